// File: rtl/estacao_reserva_add.sv
// rtl/estacao_reserva_add.sv - Adder reservation station for the Tomasulo core
//
// Holds one dispatched ADD/SUB, snoops the CDB for missing operands, runs a
// fixed-latency execute, then requests the CDB and broadcasts under TAG.
//
// Ports:
//   Clock, Resetn          clock; asynchronous active-low reset
//   Enable                 dispatch selects this station (sampled in IDLE only)
//   Opcode, Vj, Vk, Qj, Qk dispatched instruction; Q==0 means value present
//   CDB_Valid/Tag/Data     common data bus snoop
//   CDB_Grant              arbiter grants the bus to this station
//   Ready                  station free (IDLE)
//   CDB_Req                result pending, bus requested (BCAST)
//   Out_Tag, Out_Data      broadcast tag (constant TAG) and result register

module estacao_reserva_add #(
  parameter logic [2:0]  TAG       = 3'd1,
  parameter int          LATENCY   = 2,
  parameter logic [2:0]  OP_SUB    = 3'd1,
  parameter logic [15:0] SEM_VALOR = 16'hFFF0
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Enable,
  input  logic [2:0]  Opcode,
  input  logic [15:0] Vj,
  input  logic [15:0] Vk,
  input  logic [2:0]  Qj,
  input  logic [2:0]  Qk,
  input  logic        CDB_Valid,
  input  logic [2:0]  CDB_Tag,
  input  logic [15:0] CDB_Data,
  input  logic        CDB_Grant,
  output logic        Ready,
  output logic        CDB_Req,
  output logic [2:0]  Out_Tag,
  output logic [15:0] Out_Data
);

  typedef enum logic [1:0] {IDLE, WAIT_OPS, EXEC, BCAST} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state, state_nxt;
  logic [2:0]  op_r, qj_r, qk_r;
  logic [15:0] vj_r, vk_r, out_data_r;
  logic [3:0]  cnt;

  // Forwarding from the bus in the same cycle the instruction is captured.
  logic fwd_j, fwd_k;
  // Snooping for operands still outstanding while waiting.
  logic snoop_j, snoop_k;
  logic ops_ready;
  logic [15:0] result;

  assign fwd_j     = CDB_Valid && (Qj != 3'd0) && (CDB_Tag == Qj);
  assign fwd_k     = CDB_Valid && (Qk != 3'd0) && (CDB_Tag == Qk);
  assign snoop_j   = CDB_Valid && (qj_r != 3'd0) && (CDB_Tag == qj_r);
  assign snoop_k   = CDB_Valid && (qk_r != 3'd0) && (CDB_Tag == qk_r);
  // Uses the registered tags, so a value just taken off the CDB starts
  // executing one cycle later.
  assign ops_ready = (qj_r == 3'd0) && (qk_r == 3'd0);
  assign result    = (op_r == OP_SUB) ? (vj_r - vk_r) : (vj_r + vk_r);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (Enable)          state_nxt = WAIT_OPS;
      WAIT_OPS: if (ops_ready)       state_nxt = EXEC;
      EXEC:     if (cnt == 4'd0)     state_nxt = BCAST;
      BCAST:    if (CDB_Grant)       state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      op_r       <= 3'd0;
      vj_r       <= SEM_VALOR;
      vk_r       <= SEM_VALOR;
      qj_r       <= 3'd0;
      qk_r       <= 3'd0;
      cnt        <= 4'd0;
      out_data_r <= SEM_VALOR;
    end else begin
      case (state)
        IDLE: begin
          if (Enable) begin
            op_r <= Opcode;
            vj_r <= fwd_j ? CDB_Data : Vj;
            qj_r <= fwd_j ? 3'd0 : Qj;
            vk_r <= fwd_k ? CDB_Data : Vk;
            qk_r <= fwd_k ? 3'd0 : Qk;
          end
        end
        WAIT_OPS: begin
          if (snoop_j) begin
            vj_r <= CDB_Data;
            qj_r <= 3'd0;
          end
          if (snoop_k) begin
            vk_r <= CDB_Data;
            qk_r <= 3'd0;
          end
          if (ops_ready) cnt <= CNT_LOAD;
        end
        EXEC: begin
          if (cnt == 4'd0) out_data_r <= result;
          else             cnt <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign Ready    = (state == IDLE);
  assign CDB_Req  = (state == BCAST);
  assign Out_Tag  = TAG;
  assign Out_Data = out_data_r;

endmodule
